// File: rtl/binary_stream_packer.sv
// Packs a 1-bit edge-detection pixel stream LSB-first into words, tags them with
// start-of-frame / end-of-line and buffers them in a first-word-fall-through FIFO.
//
// state    | meaning
// IDLE     | after reset, waiting for vsync low so we never start mid-frame
// WAIT_SOF | between frames, waiting for vsync to rise
// ACTIVE   | inside a frame, accepting pixels and counting lines
module binary_stream_packer #(
  parameter int WORD_WIDTH = 16,
  parameter int FIFO_DEPTH = 32,
  parameter int LCNT_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset_p,
  input  logic                  pix,
  input  logic                  pix_valid,
  input  logic                  pix_hsync,
  input  logic                  pix_vsync,
  output logic [WORD_WIDTH-1:0] m_data,
  output logic                  m_user,
  output logic                  m_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  frame_done,
  output logic [LCNT_WIDTH-1:0] line_count,
  output logic                  overflow
);

  localparam int CW = $clog2(WORD_WIDTH);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = WORD_WIDTH + 2;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_SOF = 2'd1;
  localparam logic [1:0] ACTIVE   = 2'd2;

  localparam logic [CW-1:0] LAST_IDX = CW'(WORD_WIDTH - 1);

  logic [1:0]            state_q;
  logic                  sof_pend_q;
  logic                  in_line_q;
  logic [CW-1:0]         cnt_q;
  logic [WORD_WIDTH-1:0] pack_q;
  logic [WORD_WIDTH-1:0] hold_q;
  logic                  hold_v_q;
  logic [LCNT_WIDTH-1:0] lcnt_q;
  logic [LCNT_WIDTH-1:0] line_count_q;
  logic                  frame_done_q;
  logic                  overflow_q;

  logic                  accept;
  logic                  word_full;
  logic                  line_end;
  logic                  frame_end;
  logic [WORD_WIDTH-1:0] full_word;
  logic [WORD_WIDTH-1:0] partial_word;
  logic [LCNT_WIDTH-1:0] lcnt_next;

  logic                  push;
  logic [WORD_WIDTH-1:0] push_data;
  logic                  push_last;

  logic [EW-1:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [AW:0]           count_q;
  logic                  fifo_full;
  logic                  pop;
  logic                  do_push;
  logic [EW-1:0]         head;

  assign accept    = (state_q == ACTIVE) && pix_valid && pix_hsync && pix_vsync;
  assign word_full = accept && (cnt_q == LAST_IDX);
  // A frame ending while hsync is still high closes the open line first.
  assign line_end  = (state_q == ACTIVE) && in_line_q && (!pix_hsync || !pix_vsync);
  assign frame_end = (state_q == ACTIVE) && !pix_vsync;
  assign lcnt_next = !line_end ? lcnt_q :
                     (&lcnt_q) ? lcnt_q : lcnt_q + LCNT_WIDTH'(1);

  always_comb begin
    full_word = pack_q;
    full_word[cnt_q] = pix;
  end

  // Unused upper bits of a short word are padded white.
  always_comb begin
    partial_word = pack_q;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      if (i >= int'(cnt_q)) partial_word[i] = 1'b1;
    end
  end

  // The held full word is known not to end its line as soon as another pixel
  // of the same line arrives, so it is pushed then; this keeps one push per edge.
  always_comb begin
    push      = 1'b0;
    push_data = '0;
    push_last = 1'b0;
    if (accept && (cnt_q == '0) && hold_v_q) begin
      push      = 1'b1;
      push_data = hold_q;
    end else if (line_end && (cnt_q != '0)) begin
      push      = 1'b1;
      push_data = partial_word;
      push_last = 1'b1;
    end else if (line_end && hold_v_q) begin
      push      = 1'b1;
      push_data = hold_q;
      push_last = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q      <= IDLE;
      line_count_q <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= frame_end;
      case (state_q)
        IDLE:     if (!pix_vsync) state_q <= WAIT_SOF;
        WAIT_SOF: if (pix_vsync) state_q <= ACTIVE;
        ACTIVE: begin
          if (!pix_vsync) begin
            state_q      <= WAIT_SOF;
            line_count_q <= lcnt_next;
          end
        end
        default:  state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      sof_pend_q <= 1'b0;
      in_line_q  <= 1'b0;
      cnt_q      <= '0;
      pack_q     <= '0;
      hold_q     <= '0;
      hold_v_q   <= 1'b0;
      lcnt_q     <= '0;
    end else if (state_q == WAIT_SOF) begin
      if (pix_vsync) begin
        sof_pend_q <= 1'b1;
        lcnt_q     <= '0;
      end
      in_line_q <= 1'b0;
      cnt_q     <= '0;
      hold_v_q  <= 1'b0;
    end else if (state_q == ACTIVE) begin
      lcnt_q <= lcnt_next;
      if (push) sof_pend_q <= 1'b0;
      if (line_end) begin
        in_line_q <= 1'b0;
        cnt_q     <= '0;
        pack_q    <= '0;
        hold_v_q  <= 1'b0;
      end else begin
        if (pix_hsync && pix_vsync) in_line_q <= 1'b1;
        if (accept) begin
          pack_q[cnt_q] <= pix;
          if (word_full) begin
            cnt_q    <= '0;
            hold_q   <= full_word;
            hold_v_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == '0) hold_v_q <= 1'b0;
          end
        end
      end
    end
  end

  assign fifo_full = (count_q == (AW+1)'(FIFO_DEPTH));
  assign pop       = m_valid && m_ready;
  assign do_push   = push && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= {sof_pend_q, push_last, push_data};
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !pop)      count_q <= count_q + (AW+1)'(1);
      else if (!do_push && pop) count_q <= count_q - (AW+1)'(1);
      if (push && !do_push) overflow_q <= 1'b1;
    end
  end

  assign m_valid    = (count_q != '0);
  assign head       = m_valid ? mem[rd_ptr_q] : '0;
  assign m_data     = head[WORD_WIDTH-1:0];
  assign m_last     = head[WORD_WIDTH];
  assign m_user     = head[WORD_WIDTH+1];
  assign frame_done = frame_done_q;
  assign line_count = line_count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_binary_stream_packer.sv
// Directed stimulus with a scoreboard queue; a negedge monitor pops and compares
// every word the packer hands out.
module tb_binary_stream_packer;

  logic        clk = 1'b0;
  logic        reset_p;
  logic        pix, pix_valid, pix_hsync, pix_vsync;
  logic [15:0] m_data;
  logic        m_user, m_last, m_valid, m_ready;
  logic        frame_done;
  logic [11:0] line_count;
  logic        overflow;

  int vectors = 0;
  int miscompares = 0;
  logic [17:0] exp_q[$];

  binary_stream_packer #(.WORD_WIDTH(16), .FIFO_DEPTH(32), .LCNT_WIDTH(12)) dut (
    .clk(clk), .reset_p(reset_p), .pix(pix), .pix_valid(pix_valid),
    .pix_hsync(pix_hsync), .pix_vsync(pix_vsync), .m_data(m_data), .m_user(m_user),
    .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready), .frame_done(frame_done),
    .line_count(line_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic user, input logic last, input logic [15:0] data);
    exp_q.push_back({user, last, data});
  endtask

  always @(negedge clk) begin
    if (!reset_p && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_word: got %0h expected none", {m_user, m_last, m_data});
      end else begin
        chk("word", {14'd0, m_user, m_last, m_data}, {14'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // kind 0: alternating 0,1; kind 1: all 0; kind 2: word k (from 0) carries value k+1
  function automatic logic pixval(input int kind, input int i);
    logic [15:0] wv;
    wv = 16'(i / 16 + 1);
    case (kind)
      0: return (i % 2) == 1;
      1: return 1'b0;
      default: return wv[i % 16];
    endcase
  endfunction

  task automatic send_line(input int npix, input int kind, input bit gap, input bit tail);
    pix_hsync = 1'b1;
    for (int i = 0; i < npix; i++) begin
      pix = pixval(kind, i);
      pix_valid = 1'b1;
      tick();
      if (gap) begin
        pix_valid = 1'b0;
        tick();
      end
    end
    pix_valid = 1'b0;
    if (tail) begin
      pix_hsync = 1'b0;
      if (gap) begin
        pix = 1'b1;
        pix_valid = 1'b1;
      end
      tick();
      pix_valid = 1'b0;
      tick();
    end
  endtask

  task automatic frame_begin;
    pix_hsync = 1'b0;
    pix_vsync = 1'b0;
    tick();
    pix_vsync = 1'b1;
    tick();
  endtask

  task automatic frame_finish(input int exp_lines);
    pix_vsync = 1'b0;
    tick();
    chk("frame_done_pulse", frame_done, 1);
    chk("line_count", line_count, exp_lines);
    pix_hsync = 1'b0;
    tick();
    chk("frame_done_single", frame_done, 0);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    reset_p = 1'b1; pix = 1'b0; pix_valid = 1'b0; pix_hsync = 1'b0; pix_vsync = 1'b0;
    m_ready = 1'b1;
    tick(); tick();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", {m_user, m_last, m_data}, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_line_count", line_count, 0);
    chk("rst_frame_done", frame_done, 0);
    reset_p = 1'b0;

    // Test 1: two lines of alternating pixels
    expect_word(1, 1, 16'hAAAA);
    expect_word(0, 1, 16'hAAAA);
    frame_begin();
    send_line(16, 0, 0, 1);
    send_line(16, 0, 0, 1);
    frame_finish(2);
    drain(20);

    // Test 2: 20 black pixels, frame ends with hsync still high
    expect_word(1, 0, 16'h0000);
    expect_word(0, 1, 16'hFFF0);
    frame_begin();
    send_line(20, 1, 0, 0);
    frame_finish(1);
    drain(20);

    // Test 3: 33 words into a stalled 32-deep FIFO
    m_ready = 1'b0;
    for (int k = 1; k <= 32; k++) expect_word(k == 1, 0, 16'(k));
    frame_begin();
    send_line(33 * 16, 2, 0, 1);
    frame_finish(1);
    chk("ovf_m_valid", m_valid, 1);
    chk("ovf_sticky", overflow, 1);
    m_ready = 1'b1;
    drain(100);
    tick(); tick();
    chk("ovf_exactly_32", m_valid, 0);

    // Test 6: reset with 5 words queued and overflow set
    m_ready = 1'b0;
    frame_begin();
    send_line(80, 0, 0, 1);
    frame_finish(1);
    chk("pre_rst_m_valid", m_valid, 1);
    chk("pre_rst_overflow", overflow, 1);
    reset_p = 1'b1;
    tick();
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_overflow", overflow, 0);
    reset_p = 1'b0;
    m_ready = 1'b1;

    // Test 4: reset released with vsync high
    reset_p = 1'b1;
    pix_vsync = 1'b1;
    tick();
    reset_p = 1'b0;
    send_line(16, 0, 0, 1);
    tick(); tick();
    chk("midframe_ignored", m_valid, 0);
    expect_word(1, 1, 16'hAAAA);
    frame_begin();
    send_line(16, 0, 0, 1);
    frame_finish(1);
    drain(20);

    // Test 5: sparse pix_valid plus pulses outside hsync
    expect_word(1, 1, 16'hAAAA);
    expect_word(0, 1, 16'hAAAA);
    frame_begin();
    send_line(16, 0, 1, 1);
    send_line(16, 0, 1, 1);
    frame_finish(2);
    drain(20);

    // Line counter saturation with empty lines
    frame_begin();
    for (int l = 0; l < 4100; l++) begin
      pix_hsync = 1'b1;
      tick();
      pix_hsync = 1'b0;
      tick();
    end
    frame_finish(4095);
    tick(); tick();
    chk("sat_no_words", m_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
